aes_round_key_gen: RTL and testbench

//   Sequential AES-128 key schedule (FIPS-197 sec 5.2, Nk=4, Nr=10), upstream of aes_core.

---
 rtl/aes_round_key_gen_if.sv | 25 ++
 rtl/aes_round_key_gen.sv | 141 ++++++++++++++
 tb/tb_aes_round_key_gen.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_key_gen_if.sv
// Round-key handshake bundle between the key source, aes_round_key_gen and aes_core.
`default_nettype none

interface aes_round_key_gen_if;
  logic         start;
  logic [127:0] key;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk;
  logic [3:0]   round;
  logic         last;
  logic         busy;

  modport master (
    output start, key, rk_ready,
    input  rk_valid, rk, round, last, busy
  );

  modport slave (
    input  start, key, rk_ready,
    output rk_valid, rk, round, last, busy
  );
endinterface

`default_nettype wire

// File: rtl/aes_round_key_gen.sv
// Sequential AES-128 key schedule: loads a key on start and emits round keys 0..NR
// one per valid/ready handshake, using four one-cycle synchronous S-box lookups.
`default_nettype none

module aes_round_key_gen #(
  parameter int NR = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  aes_round_key_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    SUB  = 2'd2,
    CALC = 2'd3
  } state_t;

  localparam logic [3:0] NR_L = 4'(NR);

  state_t       state, state_next;
  logic [127:0] rk_q;
  logic [3:0]   round_q;
  logic [7:0]   rcon;
  logic         rk_valid_q;
  logic         busy_q;
  logic         load_key, accept, load_calc;
  logic [31:0]  sub_addr, sub_word, temp;
  logic [31:0]  w0n, w1n, w2n, w3n;
  logic [7:0]   sub_byte [4];

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, which maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign sub_addr = {rk_q[23:0], rk_q[31:24]};

  generate
    for (genvar i = 0; i < 4; i++) begin : g_sbox
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sub_byte[i] <= 8'h00;
        else          sub_byte[i] <= sbox(sub_addr[8*i +: 8]);
      end
    end
  endgenerate

  assign sub_word = {sub_byte[3], sub_byte[2], sub_byte[1], sub_byte[0]};
  assign temp     = sub_word ^ {rcon, 24'h000000};
  assign w0n      = rk_q[127:96] ^ temp;
  assign w1n      = rk_q[95:64]  ^ w0n;
  assign w2n      = rk_q[63:32]  ^ w1n;
  assign w3n      = rk_q[31:0]   ^ w2n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_key   = 1'b0;
    accept     = 1'b0;
    load_calc  = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        load_key   = 1'b1;
        state_next = EMIT;
      end
      EMIT: if (bus.rk_ready) begin
        accept     = 1'b1;
        state_next = (round_q == NR_L) ? IDLE : SUB;
      end
      SUB:  state_next = CALC;
      CALC: begin
        load_calc  = 1'b1;
        state_next = EMIT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rk_q       <= '0;
      round_q    <= '0;
      rcon       <= 8'h01;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else if (load_key) begin
      rk_q       <= bus.key;
      round_q    <= '0;
      rcon       <= 8'h01;
      rk_valid_q <= 1'b1;
      busy_q     <= 1'b1;
    end else if (accept) begin
      rk_valid_q <= 1'b0;
      if (round_q == NR_L) busy_q <= 1'b0;
    end else if (load_calc) begin
      rk_q       <= {w0n, w1n, w2n, w3n};
      round_q    <= round_q + 4'd1;
      rcon       <= xtime(rcon);
      rk_valid_q <= 1'b1;
    end
  end

  assign bus.rk_valid = rk_valid_q;
  assign bus.rk       = rk_q;
  assign bus.round    = round_q;
  assign bus.last     = rk_valid_q && (round_q == NR_L);
  assign bus.busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_round_key_gen.sv
// Scoreboard bench for aes_round_key_gen against an independent FIPS-197 key expansion.
`default_nettype none

module tb_aes_round_key_gen;

  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] rk;
  } sb_t;

  logic         clk;
  logic         reset_n;
  int           tests;
  int           fails;
  sb_t          sb_q [$];
  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [11];
  logic [127:0] seen [11];
  logic [7:0]   rcon_t [10];

  aes_round_key_gen_if bus ();

  aes_round_key_gen #(.NR(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // S-box generated by walking the multiplicative group with generator 3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    rcon_t = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon_t[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.rk_valid && bus.rk_ready) begin
      check("sb_nonempty", 128'(sb_q.size() != 0), 128'd1);
      if (sb_q.size() != 0) begin
        sb_t e;
        e = sb_q.pop_front();
        check("sb_round", 128'(bus.round), 128'(e.rnd));
        check("sb_rk", bus.rk, e.rk);
        check("sb_last", 128'(bus.last), 128'(e.rnd == 4'd10));
        seen[e.rnd] = bus.rk;
      end
    end
  end

  // Caller is #1 after a clock edge; start is sampled at the very next edge.
  task automatic do_start(input logic [127:0] k);
    expand(k);
    for (int r = 0; r < 11; r++) begin
      sb_q.push_back('{rnd: 4'(r), rk: exp_rk[r]});
      seen[r] = '0;
    end
    bus.key   = k;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.key   = ~k;
    check("start_valid", 128'(bus.rk_valid), 128'd1);
    check("start_round", 128'(bus.round), 128'd0);
    check("start_rk0", bus.rk, k);
    check("start_busy", 128'(bus.busy), 128'd1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.busy && n < 200);
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n;
    n = 0;
    while (!(bus.rk_valid && bus.round == r) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_round", 128'(bus.rk_valid && bus.round == r), 128'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 128'(bus.rk_valid), 128'd0);
    check({tag, "_rk"}, bus.rk, 128'd0);
    check({tag, "_round"}, 128'(bus.round), 128'd0);
    check({tag, "_busy"}, 128'(bus.busy), 128'd0);
    check({tag, "_last"}, 128'(bus.last), 128'd0);
  endtask

  initial begin
    int n;
    tests        = 0;
    fails        = 0;
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.key      = '0;
    bus.rk_ready = 1'b0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 A.1 with rk_ready held high
    bus.rk_ready = 1'b1;
    do_start(KEY_A);
    wait_idle(n);
    check("a1_busy_edges", 128'(n), 128'd31);
    check("a1_round1", seen[1], A_R1);
    check("a1_round10", seen[10], A_R10);
    check("a1_rk_hold", bus.rk, A_R10);
    check("a1_round_hold", 128'(bus.round), 128'd10);
    check("a1_drain", 128'(sb_q.size()), 128'd0);

    // FIPS-197 C.1
    @(posedge clk); #1;
    do_start(KEY_C);
    wait_idle(n);
    check("c1_round10", seen[10], C_R10);
    check("c1_drain", 128'(sb_q.size()), 128'd0);

    // Backpressure at round 3
    @(posedge clk); #1;
    do_start(KEY_A);
    wait_round(4'd3);
    bus.rk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 128'(bus.rk_valid), 128'd1);
      check("bp_round", 128'(bus.round), 128'd3);
      check("bp_rk", bus.rk, exp_rk[3]);
    end
    bus.rk_ready = 1'b1;
    @(posedge clk); #1;
    bus.rk_ready = 1'b0;
    check("bp_taken", 128'(bus.rk_valid), 128'd0);
    wait_round(4'd4);
    repeat (3) @(posedge clk);
    #1;
    check("bp_one_step", 128'(bus.round), 128'd4);
    check("bp_rk4", bus.rk, exp_rk[4]);
    bus.rk_ready = 1'b1;
    wait_idle(n);
    check("bp_drain", 128'(sb_q.size()), 128'd0);

    // Start with a different key mid-schedule is ignored
    @(posedge clk); #1;
    do_start(KEY_A);
    wait_round(4'd4);
    bus.key   = KEY_C;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle(n);
    check("ign_busy_edges", 128'(n), 128'd18);
    check("ign_final", bus.rk, A_R10);
    repeat (4) @(posedge clk);
    #1;
    check("ign_idle_valid", 128'(bus.rk_valid), 128'd0);
    check("ign_drain", 128'(sb_q.size()), 128'd0);

    // Async reset in SUB after round 6 handshake
    do_start(KEY_C);
    wait_round(4'd6);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_zero("areset");
    sb_q.delete();
    #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_zero("areset_hold");
    do_start(KEY_A);
    wait_idle(n);
    check("ar_busy_edges", 128'(n), 128'd31);
    check("ar_round10", seen[10], A_R10);
    check("ar_drain", 128'(sb_q.size()), 128'd0);

    // Back-to-back: second start on the first cycle busy is low
    do_start(KEY_C);
    wait_idle(n);
    check("b2b_first", seen[10], C_R10);
    do_start(KEY_A);
    wait_idle(n);
    check("b2b_busy_edges", 128'(n), 128'd31);
    check("b2b_second", seen[10], A_R10);
    check("b2b_drain", 128'(sb_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
